// File: rtl/decode_issue_stage.sv
// Decode/issue stage: holds one instruction in a decode slot and reads its operands from the
// register bank. A pending-write scoreboard keeps it from issuing on a stale operand.
module decode_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_a,
    input  logic [31:0] rf_b,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [15:0] stall_count
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // Decode slot
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;

    // Issue packet register
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_a_q, out_a_d;
    logic [31:0] out_b_q, out_b_d;
    logic [31:0] out_imm_q, out_imm_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_we_q, out_we_d;

    logic [31:0] pending_q, pending_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Decoded fields of the slot instruction
    logic [6:0]  opcode;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic        use_rs1, use_rs2, writes_rd;
    logic [31:0] imm;
    logic [4:0]  rs1_used, rs2_used, rd_dec;
    logic        we_dec;
    logic        hazard;
    logic        issue;
    logic [31:0] set_mask, clr_mask;

    always_comb begin
        opcode    = slot_instr_q[6:0];
        rd_f      = slot_instr_q[11:7];
        rs1_f     = slot_instr_q[19:15];
        rs2_f     = slot_instr_q[24:20];
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        imm       = 32'd0;
        case (opcode)
            OpR: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OpImm, OpLoad: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm       = {{20{slot_instr_q[31]}}, slot_instr_q[31:20]};
            end
            OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{slot_instr_q[31]}}, slot_instr_q[31:25], slot_instr_q[11:7]};
            end
            OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{slot_instr_q[31]}}, slot_instr_q[31], slot_instr_q[7],
                           slot_instr_q[30:25], slot_instr_q[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        rs1_used = (slot_valid_q && use_rs1) ? rs1_f : 5'd0;
        rs2_used = (slot_valid_q && use_rs2) ? rs2_f : 5'd0;
        rd_dec   = writes_rd ? rd_f : 5'd0;
        we_dec   = writes_rd && (rd_f != 5'd0);
        // pending_q[0] is held at 0, so unused sources (address 0) never raise a hazard.
        // A same-cycle writeback does not mask the hazard: the bank updates at this edge.
        hazard   = pending_q[rs1_used] || pending_q[rs2_used] || (we_dec && pending_q[rd_f]);
        issue    = slot_valid_q && !hazard && !flush && (!out_valid_q || out_ready);
        in_ready = !slot_valid_q || issue || flush;
    end

    // Scoreboard: set wins over a same-edge clear of the same bit
    always_comb begin
        set_mask     = (issue && we_dec) ? (32'd1 << rd_f) : 32'd0;
        clr_mask     = wb_valid ? (32'd1 << wb_addr) : 32'd0;
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        if (in_valid && in_ready) begin
            slot_valid_d = 1'b1;
            slot_instr_d = in_instr;
            slot_pc_d    = in_pc;
        end else if (issue || flush) begin
            slot_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_pc_d    = slot_pc_q;
            out_instr_d = slot_instr_q;
            out_a_d     = rf_a;
            out_b_d     = rf_b;
            out_imm_d   = imm;
            out_rd_d    = rd_dec;
            out_we_d    = we_dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (slot_valid_q && hazard && !flush && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q  <= 1'b0;
            slot_instr_q  <= 32'd0;
            slot_pc_q     <= 32'd0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_instr_q   <= 32'd0;
            out_a_q       <= 32'd0;
            out_b_q       <= 32'd0;
            out_imm_q     <= 32'd0;
            out_rd_q      <= 5'd0;
            out_we_q      <= 1'b0;
            pending_q     <= 32'd0;
            stall_count_q <= 16'd0;
        end else begin
            slot_valid_q  <= slot_valid_d;
            slot_instr_q  <= slot_instr_d;
            slot_pc_q     <= slot_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_imm_q     <= out_imm_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            pending_q     <= pending_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rf_addr_a   = rs1_used;
    assign rf_addr_b   = rs2_used;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_imm     = out_imm_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: a vector table of single instructions plus
// hand-written sequences for streaming, hazards, backpressure, flush and x0 handling.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_a, rf_b;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_instr, out_a, out_b, out_imm;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    // Register bank model: combinational read, write at the clock edge
    assign rf_a = regs[rf_addr_a];
    assign rf_b = regs[rf_addr_b];
    always @(posedge clk) begin
        if (wb_valid && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end

    decode_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .rf_addr_a   (rf_addr_a),
        .rf_addr_b   (rf_addr_b),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
    } vec_t;

    vec_t vec [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[0] = 32'd0;

        //           instr         pc            a            b            imm          rd     we
        vec[0] = '{32'hFFF00093, 32'h00001000, 32'h0,       32'h0,       32'hFFFFFFFF, 5'd1, 1'b1};
        vec[1] = '{32'h002082B3, 32'h00001004, 32'h101,     32'h102,     32'h0,        5'd5, 1'b1};
        vec[2] = '{32'hFFC12183, 32'h00001008, 32'h102,     32'h0,       32'hFFFFFFFC, 5'd3, 1'b1};
        vec[3] = '{32'h02732223, 32'h0000100C, 32'h106,     32'h107,     32'h24,       5'd0, 1'b0};
        vec[4] = '{32'hFE208CE3, 32'h00001010, 32'h101,     32'h102,     32'hFFFFFFF8, 5'd0, 1'b0};
        vec[5] = '{32'h1234507F, 32'h00001014, 32'h0,       32'h0,       32'h0,        5'd0, 1'b0};
        vec[6] = '{32'h00528013, 32'h00001018, 32'h105,     32'h0,       32'h5,        5'd0, 1'b0};
        vec[7] = '{32'h7FF18493, 32'h0000101C, 32'h103,     32'h0,       32'h7FF,      5'd9, 1'b1};

        in_instr = 32'd0;
        in_pc    = 32'd0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;

        // Reset with in_valid high
        rst_n     = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h0);
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_rf_addr_a", {27'd0, rf_addr_a}, 32'd0);
        check("rst_stall", {16'd0, stall_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_slot_cycle_out_valid", {31'd0, out_valid}, 32'd0);
        check("lat_rf_addr_a", {27'd0, rf_addr_a}, 32'd0);
        step();
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_pc", out_pc, 32'd0);
        check("lat_out_rd", {27'd0, out_rd}, 32'd1);

        // Table of independent instructions; pending cleared by writeback after each
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            send(vec[i].instr, vec[i].pc);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_early", i), {31'd0, out_valid}, 32'd0);
            step();
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_pc", i), out_pc, vec[i].pc);
            check($sformatf("v%0d_instr", i), out_instr, vec[i].instr);
            check($sformatf("v%0d_a", i), out_a, vec[i].a);
            check($sformatf("v%0d_b", i), out_b, vec[i].b);
            check($sformatf("v%0d_imm", i), out_imm, vec[i].imm);
            check($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vec[i].rd});
            check($sformatf("v%0d_we", i), {31'd0, out_we}, {31'd0, vec[i].we});
            step();
            if (vec[i].we) begin
                wb_valid = 1'b1;
                wb_addr  = vec[i].rd;
                wb_data  = 32'h100 + vec[i].rd;
                step();
                wb_valid = 1'b0;
            end
        end
        check("table_stall", {16'd0, stall_count}, 32'd0);
        check("table_pending", dut.pending_q, 32'd0);

        // Stream of four independent ADDIs
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                send(32'hFFF00013 | (32'(k + 1) << 7), 32'h100 + 32'(4 * k));
                check($sformatf("s%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k >= 1 && k <= 4) begin
                check($sformatf("s%0d_valid", k), {31'd0, out_valid}, 32'd1);
                check($sformatf("s%0d_rd", k), {27'd0, out_rd}, 32'(k));
                check($sformatf("s%0d_imm", k), out_imm, 32'hFFFFFFFF);
            end
        end
        check("s_drained", {31'd0, out_valid}, 32'd0);
        check("s_pending", dut.pending_q, 32'h1E);

        // Dependent pair: ADDI x1 then ADD x5,x1,x2; writeback of x1 after 3 stall cycles
        do_reset();
        send(32'hFFF00093, 32'h200);
        step();
        send(32'h002082B3, 32'h204);
        step();
        in_valid = 1'b0;
        check("dep_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        step();
        wb_valid = 1'b1;
        wb_addr  = 5'd1;
        wb_data  = 32'hCAFE0001;
        step();
        wb_valid = 1'b0;
        check("dep_not_yet", {31'd0, out_valid}, 32'd0);
        check("dep_stall_count", {16'd0, stall_count}, 32'd4);
        step();
        check("dep_valid", {31'd0, out_valid}, 32'd1);
        check("dep_pc", out_pc, 32'h204);
        check("dep_a", out_a, 32'hCAFE0001);
        check("dep_b", out_b, 32'h102);
        check("dep_stall_final", {16'd0, stall_count}, 32'd4);
        check("dep_pending", dut.pending_q, 32'h20);
        regs[1] = 32'h101;

        // Backpressure: out_ready low for 3 cycles with the slot full
        do_reset();
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h300);
        step();
        send(32'hFFF00113, 32'h304);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            step();
            check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_pc", k), out_pc, 32'h300);
            check($sformatf("bp%0d_pending", k), dut.pending_q, 32'h2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_next_pc", out_pc, 32'h304);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_pending", dut.pending_q, 32'h6);
        check("bp_stall", {16'd0, stall_count}, 32'd0);

        // Flush of a stalled instruction with a refill in the same cycle
        do_reset();
        send(32'hFFF00093, 32'h400);
        step();
        send(32'h002082B3, 32'h404);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        send(32'h00300393, 32'h408);
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_no_issue", {31'd0, out_valid}, 32'd0);
        check("fl_pending", dut.pending_q, 32'h2);
        check("fl_stall", {16'd0, stall_count}, 32'd1);
        step();
        check("fl_refill_valid", {31'd0, out_valid}, 32'd1);
        check("fl_refill_pc", out_pc, 32'h408);
        check("fl_refill_rd", {27'd0, out_rd}, 32'd7);
        check("fl_refill_imm", out_imm, 32'd3);
        check("fl_pending2", dut.pending_q, 32'h82);

        // x0 writes and unknown opcode never set pending or cause stalls
        do_reset();
        send(32'h00100013, 32'h500);
        step();
        send(32'h0000007F, 32'h504);
        step();
        check("x0_we", {31'd0, out_we}, 32'd0);
        send(32'h00000333, 32'h508);
        step();
        in_valid = 1'b0;
        check("nop_valid", {31'd0, out_valid}, 32'd1);
        check("nop_we", {31'd0, out_we}, 32'd0);
        step();
        check("add_x0_valid", {31'd0, out_valid}, 32'd1);
        check("add_x0_pc", out_pc, 32'h508);
        check("add_x0_we", {31'd0, out_we}, 32'd1);
        check("x0_stall", {16'd0, stall_count}, 32'd0);
        check("x0_pending", dut.pending_q, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
